vga_timing_dither: RTL

- Parametrised VGA raster engine: horizontal/vertical counters, frame counter, sync generation, and ordered-dither output stage.
- Successor to the fixed 1220x480 / 6-bit-to-2-bit timing block.
- Generalises timing, sync polarity, colour depths and upstream pixel latency; sync and blanking are pipelined to stay aligned with late-arriving pixel colour.
- Sits between the pixel generators (donut, checkerboard, palette) and the pad outputs.

---
 rtl/vga_timing_dither.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_dither.sv
// vga_timing_dither: parametrised VGA raster engine. It contains the horizontal, vertical and
// frame counters, the sync decode, and an ordered-dither colour output stage. Sync, blanking
// and the Bayer index pass through a PIX_LAT-deep delay line so that they stay aligned with
// colour that arrives late from the upstream pixel generators.
// Optional build macro: VGA_TEMPORAL_DITHER_EN. When it is defined, the Bayer column index is
// XORed with frame[0], so the threshold pattern alternates between odd and even frames.
module vga_timing_dither #(
  parameter int unsigned H_DISPLAY     = 1220,
  parameter int unsigned H_FRONT_PORCH = 31,
  parameter int unsigned H_SYNC_PULSE  = 183,
  parameter int unsigned H_BACK_PORCH  = 92,
  parameter int unsigned V_DISPLAY     = 480,
  parameter int unsigned V_FRONT_PORCH = 10,
  parameter int unsigned V_SYNC_PULSE  = 2,
  parameter int unsigned V_BACK_PORCH  = 33,
  parameter bit          HSYNC_POL     = 1'b0,
  parameter bit          VSYNC_POL     = 1'b0,
  parameter int unsigned PIX_LAT       = 2,
  parameter int unsigned IN_BITS       = 6,
  parameter int unsigned OUT_BITS      = 2,
  parameter int unsigned FRAME_W       = 8
) (
  input  logic                clk48,
  input  logic                rst,
  output logic [10:0]         h_count,
  output logic [9:0]          v_count,
  output logic                display_active,
  output logic                line_start,
  output logic                frame_start,
  output logic [FRAME_W-1:0]  frame,
  input  logic [IN_BITS-1:0]  r_in,
  input  logic [IN_BITS-1:0]  g_in,
  input  logic [IN_BITS-1:0]  b_in,
  output logic                hsync,
  output logic                vsync,
  output logic [OUT_BITS-1:0] r_out,
  output logic [OUT_BITS-1:0] g_out,
  output logic [OUT_BITS-1:0] b_out
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  // Bits dropped by the dither; also the width of the Bayer threshold (1..6).
  localparam int unsigned D       = IN_BITS - OUT_BITS;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_DISPLAY);
  localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FRONT_PORCH);
  localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_DISPLAY);
  localparam logic [9:0]  VS_BEG = 10'(V_DISPLAY + V_FRONT_PORCH);
  localparam logic [9:0]  VS_END = 10'(V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE);

  localparam logic [OUT_BITS-1:0] Q_MAX = '1;

  // One delay-line word: raw syncs, display enable and the Bayer index. All-zero is the
  // blank, sync-inactive state used on reset.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [2:0] j;
    logic [2:0] i;
  } pipe_t;

  logic [10:0]        h_q, h_d;
  logic [9:0]         v_q, v_d;
  logic [FRAME_W-1:0] f_q, f_d;

  logic               hs_raw, vs_raw;
  logic [2:0]         bayer_i, bayer_j;
  pipe_t              pipe_in, pipe_out;
  logic [5:0]         b6;

  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic [OUT_BITS-1:0] r_q, r_d;
  logic [OUT_BITS-1:0] g_q, g_d;
  logic [OUT_BITS-1:0] b_q, b_d;

  // Raster counter next state: h wraps each line, v on the h wrap, frame on the last pixel.
  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    f_d = f_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
        f_d = f_q + FRAME_W'(1);
      end else begin
        v_d = v_q + 10'd1;
      end
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk48) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
      f_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      f_q <= f_d;
    end
  end

  assign h_count        = h_q;
  assign v_count        = v_q;
  assign frame          = f_q;
  assign display_active = (h_q < H_ACT) && (v_q < V_ACT);
  assign line_start     = (h_q == '0);
  assign frame_start    = (h_q == '0) && (v_q == '0);

  assign hs_raw = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_raw = (v_q >= VS_BEG) && (v_q < VS_END);

`ifdef VGA_TEMPORAL_DITHER_EN
  // Frame parity is folded into the column index before the delay line, so it stays
  // attached to the pixel it was decoded for.
  assign bayer_i = h_q[2:0] ^ {2'b00, f_q[0]};
`else
  assign bayer_i = h_q[2:0];
`endif
  assign bayer_j = v_q[2:0];

  assign pipe_in = '{hs: hs_raw, vs: vs_raw, de: display_active, j: bayer_j, i: bayer_i};

  generate
    if (PIX_LAT == 0) begin : g_no_delay
      assign pipe_out = pipe_in;
    end else begin : g_delay
      pipe_t stage_q [PIX_LAT];

      // Shift register matching the upstream colour latency.
      always_ff @(posedge clk48) begin
        if (rst) begin
          for (int unsigned k = 0; k < PIX_LAT; k++) begin
            stage_q[k] <= '0;
          end
        end else begin
          stage_q[0] <= pipe_in;
          for (int unsigned k = 1; k < PIX_LAT; k++) begin
            stage_q[k] <= stage_q[k-1];
          end
        end
      end

      assign pipe_out = stage_q[PIX_LAT-1];
    end
  endgenerate

  // 8x8 Bayer matrix by bit interleave; the top D bits form the threshold.
  assign b6 = {pipe_out.i[0] ^ pipe_out.j[0], pipe_out.i[0],
               pipe_out.i[1] ^ pipe_out.j[1], pipe_out.i[1],
               pipe_out.i[2] ^ pipe_out.j[2], pipe_out.i[2]};

  // Add threshold, drop D bits, saturate. The sum needs one carry bit above the colour.
  function automatic logic [OUT_BITS-1:0] dither(input logic [IN_BITS-1:0] c,
                                                 input logic [5:0]         thr);
    logic [IN_BITS:0] sum;
    logic [IN_BITS:0] q;
    sum = (IN_BITS+1)'(32'(c) + 32'(thr >> (6 - D)));
    q   = sum >> D;
    if (q > (IN_BITS+1)'(Q_MAX)) begin
      return Q_MAX;
    end
    return q[OUT_BITS-1:0];
  endfunction

  // Output stage next state: dithered colour, forced to zero outside the display area.
  always_comb begin
    hsync_d = pipe_out.hs ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = pipe_out.vs ? VSYNC_POL : ~VSYNC_POL;
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (pipe_out.de) begin
      r_d = dither(r_in, b6);
      g_d = dither(g_in, b6);
      b_d = dither(b_in, b6);
    end
  end

  // Registered pad outputs.
  always_ff @(posedge clk48) begin
    if (rst) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign r_out = r_q;
  assign g_out = g_q;
  assign b_out = b_q;

endmodule
